// File: rtl/fmap_ctrl_pkg.sv
// rtl/fmap_ctrl_pkg.sv - shared types and helpers for the feature-map stream controller
package fmap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fmap_state_t;

    // Default accept-to-bias-adder latency of a conv layer.
    localparam int DEF_PIPE_LAT = 12;

    // One spare bit so a counter can hold its terminal value and compare against it.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/fmap_valid_delay.sv
// rtl/fmap_valid_delay.sv - fixed-depth 1-bit delay line with synchronous clear
module fmap_valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) sr <= '0;
                else     sr <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) sr <= '0;
                else     sr <= {sr[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fmap_stream_ctrl.sv
// rtl/fmap_stream_ctrl.sv - lock-step FIFO read sequencing and window-valid tracking for one conv2d filter
// Optional stall watchdog enabled by defining FMAP_CTRL_TIMEOUT_EN.
module fmap_stream_ctrl
    import fmap_ctrl_pkg::*;
#(
    parameter int NUM_CH         = 8,
    parameter int WIDTH          = 56,
    parameter int HEIGHT         = 56,
    parameter int PIPE_LAT       = DEF_PIPE_LAT,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_CH-1:0]         fifo_empty,
    output logic                      rdreq,
    output logic                      win_valid,
    output logic [$clog2(HEIGHT)-1:0] out_row,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err
);

    localparam int PW    = WIDTH + 2;
    localparam int PH    = HEIGHT + 2;
    localparam int IC_W  = cnt_w(PW);
    localparam int IR_W  = cnt_w(PH);
    localparam int OC_W  = $clog2(WIDTH * HEIGHT + 1);
    localparam int COL_W = $clog2(WIDTH);

    localparam logic [IC_W-1:0]  IC_LAST   = IC_W'(PW - 1);
    localparam logic [IR_W-1:0]  IR_LAST   = IR_W'(PH - 1);
    localparam logic [IC_W-1:0]  IC_FIRST  = IC_W'(2);
    localparam logic [IR_W-1:0]  IR_FIRST  = IR_W'(2);
    localparam logic [COL_W-1:0] OCOL_LAST = COL_W'(WIDTH - 1);
    localparam logic [OC_W-1:0]  OUT_TOTAL = OC_W'(WIDTH * HEIGHT);

    fmap_state_t     state;
    logic [IR_W-1:0] in_row;
    logic [IC_W-1:0] in_col;
    logic [OC_W-1:0] out_cnt;
    logic            accept;
    logic            tag;
    logic            stall_hit;

    assign rdreq  = (state == ST_RUN) && ~|fifo_empty;
    assign accept = rdreq;
    // Windows are complete only once two padded rows and columns are buffered.
    assign tag    = accept && (in_row >= IR_FIRST) && (in_col >= IC_FIRST);
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

`ifdef FMAP_CTRL_TIMEOUT_EN
    localparam int ST_W = cnt_w(TIMEOUT_CYCLES);

    logic [ST_W-1:0] stall_cnt;
    logic            timeout_q;

    assign stall_hit   = (state == ST_RUN) && !rdreq && (stall_cnt == ST_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (state != ST_RUN || accept) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_hit) timeout_q <= 1'b1;
        end
    end
`else
    assign stall_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            in_row <= '0;
            in_col <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        in_row <= '0;
                        in_col <= '0;
                    end
                end
                ST_RUN: begin
                    if (stall_hit) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        if (in_col == IC_LAST) begin
                            in_col <= '0;
                            in_row <= in_row + 1'b1;
                            if (in_row == IR_LAST) state <= ST_DRAIN;
                        end else begin
                            in_col <= in_col + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_cnt == OUT_TOTAL) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fmap_valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tag),
        .dout (win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && start)) begin
            out_row <= '0;
            out_col <= '0;
            out_cnt <= '0;
        end else if (win_valid) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_col == OCOL_LAST) begin
                out_col <= '0;
                out_row <= out_row + 1'b1;
            end else begin
                out_col <= out_col + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fmap_stream_ctrl.sv
// tb/tb_fmap_stream_ctrl.sv - scoreboard bench for fmap_stream_ctrl on a 4x4 frame
module tb_fmap_stream_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PL = 3;
    localparam int TO = 8;
    localparam int PW = W + 2;
    localparam int PH = H + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] fifo_empty = 8'h00;
    logic       rdreq, win_valid, busy, done, timeout_err;
    logic [1:0] out_row, out_col;

    fmap_stream_ctrl #(
        .NUM_CH         (8),
        .WIDTH          (W),
        .HEIGHT         (H),
        .PIPE_LAT       (PL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .fifo_empty  (fifo_empty),
        .rdreq       (rdreq),
        .win_valid   (win_valid),
        .out_row     (out_row),
        .out_col     (out_col),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int row;
        int col;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   m_state = 0;
    int   m_row = 0, m_col = 0, m_cnt = 0, m_stall = 0, m_acc = 0;
    int   m_to = 0;
    logic o_rd, o_wv, o_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one cycle, compare outputs against the model, then advance the model.
    task automatic tick(input logic s, input logic [7:0] fe, input logic r);
        logic exp_rd, exp_wv, drain_hit;
        start = s;
        fifo_empty = fe;
        rst = r;
        #2;
        exp_rd = (m_state == 1) && (fe == 8'h00);
        exp_wv = (q.size() > 0) && (q[0].due == cyc);
        check("rdreq", rdreq, exp_rd);
        check("busy", busy, m_state != 0);
        check("done", done, m_state == 3);
        check("win_valid", win_valid, exp_wv);
        check("timeout_err", timeout_err, m_to);
        if (exp_wv) begin
            check("out_row", out_row, q[0].row);
            check("out_col", out_col, q[0].col);
        end
        o_rd = rdreq;
        o_wv = win_valid;
        o_done = done;
        m_acc = exp_rd;
        if (r) begin
            m_state = 0; m_row = 0; m_col = 0; m_cnt = 0; m_stall = 0; m_to = 0;
            q.delete();
        end else begin
            drain_hit = (m_cnt == W * H);
            if (exp_wv) begin
                void'(q.pop_front());
                m_cnt++;
            end
            case (m_state)
                0: if (s) begin
                    m_state = 1; m_row = 0; m_col = 0; m_cnt = 0; m_stall = 0;
                end
                1: if (exp_rd) begin
                    m_stall = 0;
                    if (m_row >= 2 && m_col >= 2)
                        q.push_back('{due: cyc + PL, row: m_row - 2, col: m_col - 2});
                    if (m_col == PW - 1) begin
                        m_col = 0;
                        if (m_row == PH - 1) m_state = 2;
                        m_row++;
                    end else begin
                        m_col++;
                    end
                end else begin
`ifdef FMAP_CTRL_TIMEOUT_EN
                    m_stall++;
                    if (m_stall == TO) begin
                        m_state = 0;
                        m_to = 1;
                    end
`endif
                end
                2: if (drain_hit) m_state = 3;
                default: m_state = 0;
            endcase
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int stall_at, input int rst_at, input logic extra_start,
                             input logic [7:0] fe_all, input int exp_rd_n, input int exp_wv_n,
                             input int exp_done_n);
        int n_rd = 0, n_wv = 0, n_done = 0, n_acc = 0, stall_left = 0, k;
        logic stall_done = 1'b0;
        logic r, s;
        logic [7:0] fe;
        tick(1'b1, fe_all, 1'b0);
        for (k = 0; k < 200; k++) begin
            s = extra_start && (k % 7 == 3);
            r = (rst_at >= 0) && (n_acc == rst_at);
            if (stall_at >= 0 && !stall_done && n_acc == stall_at) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            fe = (stall_left > 0) ? 8'b0000_0100 : fe_all;
            tick(s, fe, r);
            if (stall_left > 0) stall_left--;
            n_rd += int'(o_rd);
            n_wv += int'(o_wv);
            n_done += int'(o_done);
            n_acc += m_acc;
            if (r || m_state == 0) break;
        end
        check("frame_bound", k < 200, 1'b1);
        check("accept_count", n_rd, exp_rd_n);
        check("valid_count", n_wv, exp_wv_n);
        check("done_count", n_done, exp_done_n);
    endtask

    initial begin
        @(posedge clk);
        #1;
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        tick(1'b1, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b0);

        run_frame(-1, -1, 1'b0, 8'h00, PW * PH, W * H, 1);
        tick(1'b0, 8'h00, 1'b0);
        run_frame(9, -1, 1'b0, 8'h00, PW * PH, W * H, 1);
        run_frame(-1, -1, 1'b1, 8'h00, PW * PH, W * H, 1);
        run_frame(-1, 20, 1'b0, 8'h00, 21, 4, 0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_row", out_row, 0);
        run_frame(-1, -1, 1'b0, 8'h00, PW * PH, W * H, 1);
`ifdef FMAP_CTRL_TIMEOUT_EN
        run_frame(-1, -1, 1'b0, 8'hFF, 0, 0, 0);
        tick(1'b0, 8'h00, 1'b0);
        check("timeout_sticky", timeout_err, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
`endif
        repeat (4) tick(1'b0, 8'h00, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
